// File: rtl/seg_display_pkg.sv
// Shared segment encodings, digit-position types and the BCD-to-segment decoder
// for the vending machine display scanner.
package seg_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [7:0] DIGIT_RESET = 8'b11111110;

    // Position of a digit within its 4-digit operand group.
    typedef enum logic [1:0] {
        POS_ONES     = 2'd0,
        POS_TENS     = 2'd1,
        POS_HUNDREDS = 2'd2,
        POS_UNUSED   = 2'd3
    } digit_pos_e;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary to BCD converter, one input bit
// per clock; done pulses for one cycle once the last bit has been shifted in.
module bin2bcd_seq
    import seg_display_pkg::*;
#(
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bin_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        hundreds,
    output logic [3:0]        tens,
    output logic [3:0]        ones
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_shift;
    logic [11:0]       r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [11:0]       w_adj;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    always_comb begin
        w_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    end

    // A start always wins, so a start while busy restarts from the new operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bcd   <= '0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_shift <= bin_in;
                r_bcd   <= '0;
            end else if (r_busy) begin
                r_shift <= r_shift << 1;
                r_bcd   <= (w_adj << 1) | 12'(r_shift[DATA_W-1]);
                r_cnt   <= r_cnt + 1'b1;
                if (r_cnt == LAST_SHIFT) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hundreds = r_bcd[11:8];
    assign tens     = r_bcd[7:4];
    assign ones     = r_bcd[3:0];

endmodule

// File: rtl/seg_display_scanner.sv
// Eight-digit multiplexed 7-segment scanner: price on digits 0-3, credit on
// digits 4-7, both converted to BCD once per frame with leading-zero blanking.
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] sum_in,
    input  logic [6:0] price_in,
    output logic [7:0] DIGIT,
    output logic [6:0] SEG
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_idx;
    logic [7:0]       r_digit;
    logic [3:0]       r_pr_h, r_pr_t, r_pr_o;
    logic [3:0]       r_sm_h, r_sm_t, r_sm_o;

    logic             w_div_tc;
    logic             w_frame_start;
    logic             w_pr_busy, w_pr_done, w_sm_busy, w_sm_done;
    logic [3:0]       w_pr_h, w_pr_t, w_pr_o;
    logic [3:0]       w_sm_h, w_sm_t, w_sm_o;
    logic             w_load;
    digit_pos_e       w_pos;
    logic [3:0]       w_h, w_t, w_o;
    logic [6:0]       w_seg;

    assign w_div_tc      = (r_div == DIV_LAST);
    assign w_frame_start = w_div_tc && (r_idx == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= '0;
            r_idx   <= 3'd0;
            r_digit <= DIGIT_RESET;
        end else if (w_div_tc) begin
            r_div   <= '0;
            r_idx   <= r_idx + 3'd1;
            r_digit <= ~(8'b1 << (r_idx + 3'd1));
        end else begin
            r_div   <= r_div + 1'b1;
        end
    end

    bin2bcd_seq #(.DATA_W(7)) u_price_conv (
        .clk      (clk),
        .rst      (rst),
        .start    (w_frame_start),
        .bin_in   (price_in),
        .busy     (w_pr_busy),
        .done     (w_pr_done),
        .hundreds (w_pr_h),
        .tens     (w_pr_t),
        .ones     (w_pr_o)
    );

    bin2bcd_seq #(.DATA_W(7)) u_sum_conv (
        .clk      (clk),
        .rst      (rst),
        .start    (w_frame_start),
        .bin_in   (sum_in),
        .busy     (w_sm_busy),
        .done     (w_sm_done),
        .hundreds (w_sm_h),
        .tens     (w_sm_t),
        .ones     (w_sm_o)
    );

    // Both operands update together; a result already superseded by a restart is dropped.
    assign w_load = w_pr_done && w_sm_done && !w_pr_busy && !w_sm_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pr_h <= 4'd0;
            r_pr_t <= 4'd0;
            r_pr_o <= 4'd0;
            r_sm_h <= 4'd0;
            r_sm_t <= 4'd0;
            r_sm_o <= 4'd0;
        end else if (w_load) begin
            r_pr_h <= w_pr_h;
            r_pr_t <= w_pr_t;
            r_pr_o <= w_pr_o;
            r_sm_h <= w_sm_h;
            r_sm_t <= w_sm_t;
            r_sm_o <= w_sm_o;
        end
    end

    always_comb begin
        w_pos = digit_pos_e'(r_idx[1:0]);
        w_h   = r_idx[2] ? r_sm_h : r_pr_h;
        w_t   = r_idx[2] ? r_sm_t : r_pr_t;
        w_o   = r_idx[2] ? r_sm_o : r_pr_o;
        w_seg = SEG_BLANK;
        case (w_pos)
            POS_ONES:     w_seg = bcd_to_seg(w_o);
            POS_TENS:     w_seg = (w_t == 4'd0 && w_h == 4'd0) ? SEG_BLANK : bcd_to_seg(w_t);
            POS_HUNDREDS: w_seg = (w_h == 4'd0) ? SEG_BLANK : bcd_to_seg(w_h);
            default:      w_seg = SEG_BLANK;
        endcase
    end

    assign DIGIT = r_digit;
    assign SEG   = w_seg;

endmodule
